aa_stream_filter: RTL and testbench

- Streaming, parametrised successor to the team's frame-array anti-aliasing block.
- Accepts one pixel per cycle in raster order over a valid/ready interface and emits a filtered frame of the same size, in the same order, over a valid/ready interface.
- Edge pixels are replaced by a neighbour average:
  - an edge pixel is above threshold and has at least one 4-neighbour below threshold;
  - all other pixels pass through unchanged.
- Sits between the frame source and the display/frame-store writer. Storage is a (2*WIDTH+1)-pixel window, not a full frame.

---
 rtl/aa_stream_filter.sv | 168 ++++++++++++++++
 tb/tb_aa_stream_filter.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aa_stream_filter.sv
// Streaming anti-aliasing filter: replaces edge pixels with a neighbour mean using a (2*WIDTH+1)-pixel window.
// Optional build macro AA_DIV5_EN selects a 5-pixel approximate mean instead of the 4-neighbour mean.
module aa_stream_filter #(
    parameter int PIX_W  = 10,
    parameter int WIDTH  = 640,
    parameter int HEIGHT = 480
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [PIX_W-1:0] th,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [PIX_W-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [PIX_W-1:0] out_data,
    output logic             out_last,
    output logic             done
);

    localparam int P  = WIDTH * HEIGHT;
    localparam int M  = 2 * WIDTH + 1;
    localparam int CW = $clog2(P + 1);
    localparam int AW = $clog2(M);
    localparam int XW = $clog2(WIDTH);
    localparam int YW = $clog2(HEIGHT);

    typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

    state_t           state, state_nxt;
    logic [PIX_W-1:0] win [M];
    logic [PIX_W-1:0] th_q;
    logic [CW-1:0]    in_cnt, out_cnt, ld_cnt;
    logic [CW-1:0]    in_cnt_nxt, out_cnt_nxt;
    logic [AW-1:0]    wr_ptr, ld_ptr;
    logic [XW-1:0]    ld_col;
    logic [YW-1:0]    ld_row;
    logic             in_hs, out_hs, frame_end, eligible, load, in_ready_nxt;
    logic [PIX_W-1:0] pix_c, pix_n, pix_s, pix_w, pix_e;
    logic [PIX_W-1:0] avg, filt;
    logic             border, is_edge;

    // Pixel k always lives in slot k mod M, so neighbours are fixed offsets around the load pointer.
    function automatic logic [AW-1:0] ptr_fwd(input logic [AW-1:0] p, input int d);
        logic [AW:0] s;
        s = {1'b0, p} + (AW+1)'(d);
        if (s >= (AW+1)'(M))
            s = s - (AW+1)'(M);
        return s[AW-1:0];
    endfunction

    function automatic logic [AW-1:0] ptr_back(input logic [AW-1:0] p, input int d);
        return ptr_fwd(p, M - d);
    endfunction

    assign pix_c = win[ld_ptr];
    assign pix_n = win[ptr_back(ld_ptr, WIDTH)];
    assign pix_s = win[ptr_fwd(ld_ptr, WIDTH)];
    assign pix_w = win[ptr_back(ld_ptr, 1)];
    assign pix_e = win[ptr_fwd(ld_ptr, 1)];

`ifdef AA_DIV5_EN
    logic [PIX_W+2:0]  sum5;
    logic [PIX_W+10:0] prod;
    logic [PIX_W:0]    quot;

    assign sum5 = (PIX_W+3)'(pix_c) + (PIX_W+3)'(pix_n) + (PIX_W+3)'(pix_s)
                + (PIX_W+3)'(pix_w) + (PIX_W+3)'(pix_e);
    assign prod = (PIX_W+11)'(sum5) * (PIX_W+11)'(205);
    assign quot = (PIX_W+1)'(prod >> 10);
    assign avg  = (quot > (PIX_W+1)'({PIX_W{1'b1}})) ? {PIX_W{1'b1}} : quot[PIX_W-1:0];
`else
    logic [PIX_W+1:0] sum4;

    assign sum4 = (PIX_W+2)'(pix_n) + (PIX_W+2)'(pix_s) + (PIX_W+2)'(pix_w) + (PIX_W+2)'(pix_e);
    assign avg  = PIX_W'(sum4 >> 2);
`endif

    always_comb begin
        border  = (ld_row == '0) || (ld_row == YW'(HEIGHT - 1))
               || (ld_col == '0) || (ld_col == XW'(WIDTH - 1));
        is_edge = (pix_c > th_q)
               && ((pix_n < th_q) || (pix_s < th_q) || (pix_w < th_q) || (pix_e < th_q));
        filt    = (is_edge && !border) ? avg : pix_c;
    end

    always_comb begin
        in_hs       = in_valid && in_ready;
        out_hs      = out_valid && out_ready;
        frame_end   = out_hs && (out_cnt == CW'(P - 1));
        eligible    = (ld_cnt != CW'(P))
                   && ((state == FLUSH) || ({1'b0, in_cnt} >= {1'b0, ld_cnt} + (CW+1)'(WIDTH + 1)));
        load        = eligible && (!out_valid || out_hs);
        in_cnt_nxt  = frame_end ? '0 : in_cnt + CW'(in_hs);
        out_cnt_nxt = frame_end ? '0 : out_cnt + CW'(out_hs);
        state_nxt   = state;
        case (state)
            IDLE:    if (in_hs) state_nxt = RUN;
            RUN:     if (in_cnt_nxt == CW'(P)) state_nxt = FLUSH;
            FLUSH:   if (frame_end) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        in_ready_nxt = (state_nxt == IDLE)
                    || ((state_nxt == RUN) && ((in_cnt_nxt - out_cnt_nxt) <= CW'(WIDTH)));
    end

    // Window storage needs no reset: counters decide which slots hold live pixels.
    always_ff @(posedge clk) begin
        if (in_hs)
            win[wr_ptr] <= in_data;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            th_q      <= '0;
            in_cnt    <= '0;
            out_cnt   <= '0;
            ld_cnt    <= '0;
            wr_ptr    <= '0;
            ld_ptr    <= '0;
            ld_col    <= '0;
            ld_row    <= '0;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
            done      <= 1'b0;
        end else begin
            state    <= state_nxt;
            in_cnt   <= in_cnt_nxt;
            out_cnt  <= out_cnt_nxt;
            in_ready <= in_ready_nxt;
            done     <= frame_end;
            if (state == IDLE && in_hs)
                th_q <= th;
            if (frame_end)
                wr_ptr <= '0;
            else if (in_hs)
                wr_ptr <= ptr_fwd(wr_ptr, 1);
            if (frame_end) begin
                ld_cnt <= '0;
                ld_ptr <= '0;
                ld_col <= '0;
                ld_row <= '0;
            end else if (load) begin
                ld_cnt <= ld_cnt + 1'b1;
                ld_ptr <= ptr_fwd(ld_ptr, 1);
                if (ld_col == XW'(WIDTH - 1)) begin
                    ld_col <= '0;
                    ld_row <= ld_row + 1'b1;
                end else begin
                    ld_col <= ld_col + 1'b1;
                end
            end
            // The output register refills in the same cycle it is handshaked, so a stall holds data stable.
            if (load) begin
                out_valid <= 1'b1;
                out_data  <= filt;
                out_last  <= (ld_cnt == CW'(P - 1));
            end else if (out_hs) begin
                out_valid <= 1'b0;
                out_last  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_aa_stream_filter.sv
// Scoreboard bench for aa_stream_filter: directed and random frames against a pixel-rule reference model.
module tb_aa_stream_filter;

    localparam int PW = 8;
    localparam int W  = 8;
    localparam int H  = 5;
    localparam int P  = W * H;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [PW-1:0] th = '0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [PW-1:0] in_data = '0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [PW-1:0] out_data;
    logic          out_last;
    logic          done;

    int            total = 0;
    int            bad = 0;
    logic [PW-1:0] frame_pix [P];
    int            exp_data [$];
    int            exp_last [$];
    bit            rand_ready = 0;
    int            tb_in = 0;
    int            tb_out = 0;
    bit            post_rst = 0;
    bit            done_exp = 0;
    bit            prev_stall = 0;
    int            prev_data = 0;
    int            prev_last = 0;
    int            bp_cycles = 0;

    aa_stream_filter #(.PIX_W(PW), .WIDTH(W), .HEIGHT(H)) dut (
        .clk       (clk),
        .reset     (reset),
        .th        (th),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .done      (done)
    );

    always #5 clk = ~clk;

    // Reference: each output pixel derived directly from its 4-neighbourhood in the stored frame.
    function automatic int refPixel(input int k, input int thv);
        int r, c, cv, nv, sv, wv, ev;
        bit is_edge;
        r  = k / W;
        c  = k % W;
        cv = int'(frame_pix[k]);
        if (r == 0 || r == H - 1 || c == 0 || c == W - 1)
            return cv;
        nv = int'(frame_pix[k - W]);
        sv = int'(frame_pix[k + W]);
        wv = int'(frame_pix[k - 1]);
        ev = int'(frame_pix[k + 1]);
        is_edge = (cv > thv) && (nv < thv || sv < thv || wv < thv || ev < thv);
        if (!is_edge)
            return cv;
`ifdef AA_DIV5_EN
        if ((cv + nv + sv + wv + ev) * 205 / 1024 > 255)
            return 255;
        return (cv + nv + sv + wv + ev) * 205 / 1024;
`else
        return (nv + sv + wv + ev) / 4;
`endif
    endfunction

    task automatic checkVal(input string name, input int actual, input int required);
        total++;
        if (actual != required) begin
            bad++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, required);
        end
    endtask

    task automatic checkOutput();
        int d, l;
        if (exp_data.size() == 0) begin
            total++;
            bad++;
            $display("[TB] FAIL unexpected_output: got data %0d, expected no output", out_data);
        end else begin
            d = exp_data.pop_front();
            l = exp_last.pop_front();
            checkVal("out_data", int'(out_data), d);
            checkVal("out_last", int'(out_last), l);
        end
    endtask

    task automatic fillConst(input int v);
        for (int k = 0; k < P; k++) frame_pix[k] = PW'(v);
    endtask

    task automatic fillRand();
        for (int k = 0; k < P; k++) frame_pix[k] = PW'($urandom_range(0, 255));
    endtask

    task automatic setPix(input int r, input int c, input int v);
        frame_pix[r * W + c] = PW'(v);
    endtask

    // Expected values are queued before driving; th changes after pixel 0 to exercise the latch.
    task automatic applyStimulus(input int n_pix, input int th_v, input bit rand_valid);
        bit accepted;
        int guard;
        int gaps;
        for (int k = 0; k < P; k++) begin
            exp_data.push_back(refPixel(k, th_v));
            exp_last.push_back((k == P - 1) ? 1 : 0);
        end
        for (int k = 0; k < n_pix; k++) begin
            gaps = 0;
            while (rand_valid && gaps < 4 && $urandom_range(0, 2) == 0) begin
                in_valid = 1'b0;
                @(posedge clk);
                #1;
                gaps++;
            end
            in_valid = 1'b1;
            in_data  = frame_pix[k];
            th       = (k == 0) ? PW'(th_v) : PW'($urandom_range(0, 255));
            accepted = 0;
            guard    = 0;
            while (!accepted && guard < 500) begin
                @(negedge clk);
                accepted = in_ready;
                @(posedge clk);
                #1;
                guard++;
            end
            if (!accepted) begin
                checkVal("input_accept_timeout", 0, 1);
                break;
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic waitFrame();
        for (int i = 0; i < 2000 && exp_data.size() != 0; i++) begin
            @(posedge clk);
            #1;
        end
        checkVal("frame_drained_remaining", exp_data.size(), 0);
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        @(posedge clk);
        #1;
        reset    = 1'b1;
        in_valid = 1'b0;
        #1;
        checkVal("rst_out_valid", int'(out_valid), 0);
        checkVal("rst_out_data", int'(out_data), 0);
        checkVal("rst_out_last", int'(out_last), 0);
        checkVal("rst_done", int'(done), 0);
        checkVal("rst_in_ready", int'(in_ready), 0);
        exp_data.delete();
        exp_last.delete();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #1;
            out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    always @(posedge clk) post_rst = !reset;

    // Monitor: scoreboard pops, stall stability, in_ready window rule and done pulse timing.
    always @(negedge clk) begin
        if (reset) begin
            tb_in      = 0;
            tb_out     = 0;
            done_exp   = 0;
            prev_stall = 0;
        end else begin
            if (post_rst) begin
                checkVal("in_ready", int'(in_ready), ((tb_in - tb_out) <= W && tb_in < P) ? 1 : 0);
                checkVal("done", int'(done), int'(done_exp));
            end
            if (prev_stall) begin
                checkVal("hold_valid", int'(out_valid), 1);
                checkVal("hold_data", int'(out_data), prev_data);
                checkVal("hold_last", int'(out_last), prev_last);
            end
            if (in_valid && !in_ready && tb_in > 0 && tb_in < P)
                bp_cycles++;
            done_exp = 0;
            if (out_valid && out_ready) begin
                checkOutput();
                tb_out++;
                if (tb_out == P) begin
                    done_exp = 1;
                    tb_in    = 0;
                    tb_out   = 0;
                end
            end
            if (in_valid && in_ready)
                tb_in++;
            prev_stall = out_valid && !out_ready;
            prev_data  = int'(out_data);
            prev_last  = int'(out_last);
        end
    end

    initial begin
        int th_r;
        repeat (3) @(posedge clk);
        #1;
        checkVal("init_out_valid", int'(out_valid), 0);
        checkVal("init_out_data", int'(out_data), 0);
        checkVal("init_in_ready", int'(in_ready), 0);
        checkVal("init_done", int'(done), 0);
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        $display("[TB] flat frame");
        fillConst(50);
        applyStimulus(P, 128, 0);
        waitFrame();

        $display("[TB] interior edge and border pixel");
        fillConst(100);
        setPix(1, 1, 200);
        setPix(0, 2, 200);
        applyStimulus(P, 128, 0);
        waitFrame();

        $display("[TB] threshold equality");
        fillConst(128);
        setPix(2, 3, 200);
        setPix(2, 6, 200);
        setPix(2, 5, 127);
        applyStimulus(P, 128, 0);
        waitFrame();

        $display("[TB] random frames with random out_ready");
        rand_ready = 1;
        bp_cycles  = 0;
        for (int f = 0; f < 4; f++) begin
            fillRand();
            th_r = $urandom_range(64, 192);
            applyStimulus(P, th_r, (f == 3) ? 1'b1 : 1'b0);
            waitFrame();
        end
        checkVal("backpressure_seen", (bp_cycles > 0) ? 1 : 0, 1);

        $display("[TB] reset mid-frame");
        fillRand();
        applyStimulus(10, 100, 0);
        doReset();
        repeat (2) @(posedge clk);
        #1;
        fillRand();
        applyStimulus(P, 50, 0);
        waitFrame();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
